// File: rtl/contador_decrescente.sv
// Presettable, cascadable down counter with ripple borrow and an optional reload register.
// On an enabled underflow it either wraps to all-ones or reloads the last loaded preset.
module contador_decrescente #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             RBO,
    output logic             ZERO,
    output logic             DONE
);

    logic [WIDTH-1:0] reload;
    logic             at_zero;
    logic             at_one;

    assign at_zero = (Q == '0);
    assign at_one  = (Q == WIDTH'(1));

    // LD beats counting. DONE is set only on the counted 1 -> 0 step, never by a load.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q      <= '0;
            reload <= '0;
            DONE   <= 1'b0;
        end else if (!LD) begin
            Q      <= D;
            reload <= D;
            DONE   <= 1'b0;
        end else if (ENP && ENT) begin
            if (!at_zero) begin
                Q    <= Q - WIDTH'(1);
                DONE <= at_one;
            end else begin
                Q    <= AUTO_RELOAD ? reload : '1;
                DONE <= 1'b0;
            end
        end else begin
            DONE <= 1'b0;
        end
    end

    assign ZERO = at_zero;
    assign RBO  = ENT && at_zero;

endmodule

// File: tb/tb_contador_decrescente.sv
// Directed-vector bench for contador_decrescente: wrap, auto-reload and a two-stage cascade.
module tb_contador_decrescente;

    logic       clk;
    logic       clr;

    logic       ld_a, enp_a, ent_a;
    logic [3:0] d_a, q_a;
    logic       rbo_a, zero_a, done_a;

    logic       ld_b, enp_b, ent_b;
    logic [3:0] d_b, q_b;
    logic       rbo_b, zero_b, done_b;

    logic       ld_c, enp_c, ent_c;
    logic [7:0] d_c;
    logic [3:0] q0, q1;
    logic       rbo0, rbo1, zero0, zero1, done0, done1;

    int vectors;
    int miscompares;
    int done_pulses;

    logic [3:0] exp_q_a    [5] = '{4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
    logic       exp_done_a [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_q_b    [6] = '{4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h2};
    logic       exp_done_b [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    contador_decrescente #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_wrap (
        .CLK(clk), .CLR(clr), .LD(ld_a), .D(d_a), .ENP(enp_a), .ENT(ent_a),
        .Q(q_a), .RBO(rbo_a), .ZERO(zero_a), .DONE(done_a)
    );

    contador_decrescente #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_reload (
        .CLK(clk), .CLR(clr), .LD(ld_b), .D(d_b), .ENP(enp_b), .ENT(ent_b),
        .Q(q_b), .RBO(rbo_b), .ZERO(zero_b), .DONE(done_b)
    );

    contador_decrescente #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_stage0 (
        .CLK(clk), .CLR(clr), .LD(ld_c), .D(d_c[3:0]), .ENP(enp_c), .ENT(ent_c),
        .Q(q0), .RBO(rbo0), .ZERO(zero0), .DONE(done0)
    );

    contador_decrescente #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_stage1 (
        .CLK(clk), .CLR(clr), .LD(ld_c), .D(d_c[7:4]), .ENP(enp_c), .ENT(rbo0),
        .Q(q1), .RBO(rbo1), .ZERO(zero1), .DONE(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the given number of rising edges and settle just after the last one.
    task automatic applyStimulus(input int edges);
        for (int e = 0; e < edges; e++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_pulses = 0;
        clr = 1'b0;
        ld_a = 1'b1; d_a = 4'h0; enp_a = 1'b0; ent_a = 1'b1;
        ld_b = 1'b1; d_b = 4'h0; enp_b = 1'b0; ent_b = 1'b0;
        ld_c = 1'b1; d_c = 8'h00; enp_c = 1'b0; ent_c = 1'b0;

        #2;
        checkOutput("reset_q", q_a, 4'h0);
        checkOutput("reset_zero", zero_a, 1'b1);
        checkOutput("reset_done", done_a, 1'b0);
        checkOutput("reset_rbo", rbo_a, 1'b1);
        #1 clr = 1'b1;

        // Asynchronous clear in the middle of a cycle with Q = 9
        ld_a = 1'b0; d_a = 4'h9;
        applyStimulus(1);
        ld_a = 1'b1;
        checkOutput("load9_q", q_a, 4'h9);
        #1 clr = 1'b0;
        #1;
        checkOutput("clr_async_q", q_a, 4'h0);
        checkOutput("clr_async_done", done_a, 1'b0);
        checkOutput("clr_async_rbo", rbo_a, 1'b1);
        #1 clr = 1'b1;

        ld_a = 1'b0; d_a = 4'hA;
        applyStimulus(1);
        checkOutput("loadA_q", q_a, 4'hA);
        checkOutput("loadA_rbo", rbo_a, 1'b0);
        checkOutput("loadA_zero", zero_a, 1'b0);

        // Countdown with wrap
        d_a = 4'h3;
        applyStimulus(1);
        checkOutput("load3_q", q_a, 4'h3);
        checkOutput("load3_done", done_a, 1'b0);
        ld_a = 1'b1; enp_a = 1'b1; ent_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("wrap_q", q_a, exp_q_a[i]);
            checkOutput("wrap_done", done_a, exp_done_a[i]);
            checkOutput("wrap_rbo", rbo_a, exp_done_a[i]);
        end

        // Enable gating
        ld_a = 1'b0; d_a = 4'h5; enp_a = 1'b0;
        applyStimulus(1);
        ld_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("enp_low_q", q_a, 4'h5);
            checkOutput("enp_low_rbo", rbo_a, 1'b0);
        end
        ld_a = 1'b0; d_a = 4'h0;
        applyStimulus(1);
        checkOutput("load0_q", q_a, 4'h0);
        checkOutput("load0_done", done_a, 1'b0);
        checkOutput("enp_low_zero_rbo", rbo_a, 1'b1);
        ld_a = 1'b1; ent_a = 1'b0; enp_a = 1'b1;
        #1;
        checkOutput("ent_low_rbo", rbo_a, 1'b0);
        applyStimulus(1);
        checkOutput("ent_low_hold_q", q_a, 4'h0);
        checkOutput("ent_low_zero", zero_a, 1'b1);

        // Load wins over underflow
        ent_a = 1'b1; ld_a = 1'b0; d_a = 4'h7;
        applyStimulus(1);
        checkOutput("ld_priority_q", q_a, 4'h7);
        checkOutput("ld_priority_done", done_a, 1'b0);
        ld_a = 1'b1; enp_a = 1'b0;

        // Auto-reload countdown
        ld_b = 1'b0; d_b = 4'h2;
        applyStimulus(1);
        ld_b = 1'b1; enp_b = 1'b1; ent_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            checkOutput("reload_q", q_b, exp_q_b[i]);
            checkOutput("reload_done", done_b, exp_done_b[i]);
            if (done_b) done_pulses++;
        end
        checkOutput("reload_pulses", done_pulses, 2);

        // Reload register of zero keeps the counter parked at zero
        ld_b = 1'b0; d_b = 4'h0;
        applyStimulus(1);
        ld_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1);
            checkOutput("r0_q", q_b, 4'h0);
            checkOutput("r0_done", done_b, 1'b0);
            checkOutput("r0_rbo", rbo_b, 1'b1);
            checkOutput("r0_zero", zero_b, 1'b1);
        end
        ld_b = 1'b0; d_b = 4'h1;
        applyStimulus(1);
        checkOutput("r_ld_q", q_b, 4'h1);
        checkOutput("r_ld_done", done_b, 1'b0);
        ld_b = 1'b1;
        applyStimulus(1);
        checkOutput("r_one_q", q_b, 4'h0);
        checkOutput("r_one_done", done_b, 1'b1);
        applyStimulus(1);
        checkOutput("r_new_reload_q", q_b, 4'h1);
        checkOutput("r_new_reload_done", done_b, 1'b0);
        enp_b = 1'b0;

        // Two-stage cascade
        ld_c = 1'b0; d_c = 8'h10;
        applyStimulus(1);
        ld_c = 1'b1;
        checkOutput("casc_load", {q1, q0}, 8'h10);
        checkOutput("casc_zero0", zero0, 1'b1);
        checkOutput("casc_zero1", zero1, 1'b0);
        checkOutput("casc_rbo1", rbo1, 1'b0);
        checkOutput("casc_done0", done0, 1'b0);
        enp_c = 1'b1; ent_c = 1'b1;
        applyStimulus(1);
        checkOutput("casc_step1", {q1, q0}, 8'h0F);
        checkOutput("casc_done1", done1, 1'b1);
        applyStimulus(1);
        checkOutput("casc_step2", {q1, q0}, 8'h0E);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/contador_decrescente.md
Name: contador_decrescente

Overview:
- Synchronous, cascadable, presettable down counter.
- Mirrors the team's 74163-style up counter: same LD/ENP/ENT control set and the same cascade scheme, but counts downward and emits a borrow instead of a carry.
- Used in the counter/comparator experiments as the countdown side, i.e. timers and "remaining items" counters.
- Adds a reload register and a registered terminal pulse, so a chain can run as a periodic down-timer without external glue.

Parameters:
- WIDTH, 4, counter width in bits.
- AUTO_RELOAD, 0, 1 = on underflow, reload from the captured preset; 0 = wrap to all-ones.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous clear, active-low.
- LD  input  1  synchronous parallel load, active-low.
- D  input  WIDTH  parallel preset data, MSB first.
- ENP  input  1  parallel count enable, active-high.
- ENT  input  1  trickle count enable, active-high; also gates RBO.
- Q  output  WIDTH  current count.
- RBO  output  1  ripple borrow out, combinational.
- ZERO  output  1  combinational, Q == 0.
- DONE  output  1  registered one-cycle pulse on a counted 1->0 transition.

Behaviour:
- One clock domain, CLK. Reset is asynchronous and active-low (CLR); it acts immediately, independent of CLK.
- While CLR = 0:
  - Q = 0, reload register R = 0, DONE = 0.
  - RBO = ENT (because Q = 0); ZERO = 1.
- On CLR release, the first rising edge evaluates the normal priority below.
- Per rising edge of CLK with CLR = 1, priority is LD > count > hold:
  - LD = 0: Q <= D, R <= D, DONE <= 0. ENP and ENT are ignored.
  - LD = 1, ENP = 1, ENT = 1, Q != 0: Q <= Q - 1. DONE <= 1 iff Q == 1, else 0.
  - LD = 1, ENP = 1, ENT = 1, Q == 0 (underflow):
    - AUTO_RELOAD = 0: Q <= all-ones (modulo 2^WIDTH wrap).
    - AUTO_RELOAD = 1: Q <= R.
    - DONE <= 0 in both cases.
  - Otherwise (hold): Q unchanged, DONE <= 0.
- Outputs:
  - RBO = ENT && (Q == 0), combinational, no register. It mirrors the up counter's RCO so chains ripple: RBO of stage n drives ENT of stage n+1, with ENP shared.
  - ZERO = (Q == 0), independent of ENT.
  - DONE never stays high more than one cycle during continuous counting.
    - A load of D = 0 does not assert DONE.
    - A load of 1 followed by one count does assert DONE.
- Arithmetic: unsigned, WIDTH bits, all wrap modulo 2^WIDTH; no saturation.
- Boundary cases:
  - AUTO_RELOAD = 1 with R = 0: the counter stays at 0 while enabled. RBO stays 1 if ENT = 1; DONE stays 0.
  - LD asserted in the same cycle as underflow: the load wins, and R takes the new D.
  - CLR asserted mid-count: Q drops to 0 without waiting for a clock edge, and any pending DONE is cleared.
  - ENT = 0 with ENP = 1: hold, and RBO = 0.
  - ENP = 0 with ENT = 1: hold, and RBO follows Q == 0.
- Latency: Q updates 1 cycle after the controlling edge. DONE is registered, so it is high in the cycle where Q first shows 0.

Test Plan:
- Reset and load: CLR = 0 mid-run with Q = 9 -> Q = 0, DONE = 0, RBO = 1 (ENT = 1), all before the next edge. Then release CLR, LD = 0, D = 4'hA, one edge -> Q = 4'hA, RBO = 0, ZERO = 0.
- Countdown, AUTO_RELOAD = 0: load 3, then ENP = ENT = 1 for 5 edges -> Q = 2, 1, 0, F, E. DONE is high only in the cycle with Q = 0. RBO is high only while Q = 0.
- Countdown, AUTO_RELOAD = 1: load 2, enable for 6 edges -> Q = 1, 0, 2, 1, 0, 2. DONE pulses twice, each one cycle wide.
- Enable gating: Q = 5. ENP = 0, ENT = 1 for 3 edges -> Q stays 5. Then ENT = 0, Q = 0 -> RBO = 0 and Q holds.
- Cascade: two WIDTH = 4 instances, stage-0 RBO -> stage-1 ENT, loaded with 8'h10, enabled for 2 edges -> {Q1, Q0} = 0F, then 0E. Stage 1 decrements only on the edge where stage 0 is at 0.
- Load priority: Q = 0, enables high, LD = 0, D = 7 on the same edge -> Q = 7, R = 7, DONE = 0, and no wrap to F.
